memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Parametrised N-channel arbiter. Multiplexes the NockPU engines (traversal, execute, cell, incr, equal, edit, …) onto the single memory_unit command port.
- Supersedes combinational select muxing with latched commands, a one-cycle execute pulse and a completion handshake back to the owning channel.
- Two arbitration modes: external select (legacy sel-driven behaviour) and round-robin (free-running engines).
- Sits between the engines and memory_unit; owns the memory command port exclusively.

Parameters:
- NUM_CH, 6: number of requesting channels, 2..16.
- ADDR_W, `memory_addr_width: address1/address2 width.
- DATA_W, `memory_data_width: write/read data width.
- SEL_W, 4: width of sel_in; must satisfy 2^SEL_W >= NUM_CH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- mode  in  1  0 = external select via sel_in, 1 = round-robin.
- sel_in  in  SEL_W  channel index used in mode 0.
- ch_req  in  NUM_CH  per-channel request level; held until that channel's ch_done.
- ch_mem_func  in  2*NUM_CH  packed; channel i occupies bits [2i+1:2i].
- ch_address1  in  ADDR_W*NUM_CH  packed per channel.
- ch_address2  in  ADDR_W*NUM_CH  packed per channel.
- ch_write_data  in  DATA_W*NUM_CH  packed per channel.
- ch_done  out  NUM_CH  one-hot, one-cycle completion pulse to the granted channel.
- ch_grant  out  NUM_CH  one-hot; current owner, held from ISSUE through DONE.
- rd_data  out  DATA_W  memory read data, valid while ch_done is nonzero, held afterwards.
- mem_func  out  2  command to memory_unit.
- execute  out  1  one-cycle start strobe to memory_unit.
- address1  out  ADDR_W  command address 1.
- address2  out  ADDR_W  command address 2.
- write_data  out  DATA_W  command write data.
- mem_ready  in  1  memory_unit completion strobe.
- mem_read_data  in  DATA_W  memory read result, valid with mem_ready.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - state = IDLE, rr_ptr = 0.
  - All outputs 0: ch_done, ch_grant, rd_data, mem_func, execute, address1, address2, write_data, busy.
  - Reset asserted in any state aborts the transaction. No ch_done is issued; the requester must re-request.
- All outputs are registered. States: IDLE, ISSUE, WAIT, DONE.
- IDLE, winner selection from ch_req:
  - mode 0: winner = sel_in, only if sel_in < NUM_CH and ch_req[sel_in] = 1. Otherwise no grant and stay in IDLE.
  - mode 1: first channel with ch_req set, searching rr_ptr, rr_ptr+1, …, wrapping modulo NUM_CH.
  - On a winner: latch that channel's mem_func/address1/address2/write_data into the output registers, set ch_grant, go to ISSUE.
- ISSUE: execute = 1 for exactly this cycle; command outputs stable. Next state is DONE if mem_ready = 1 this cycle, else WAIT.
- WAIT:
  - execute = 0; command outputs held.
  - On mem_ready = 1: capture mem_read_data into rd_data, go to DONE.
  - No timeout.
- DONE:
  - ch_done[granted] = 1 for one cycle.
  - In mode 1, rr_ptr = (granted+1) mod NUM_CH, wrapping NUM_CH-1 to 0.
  - Clear ch_grant, return to IDLE. rd_data is held.
- mem_ready outside ISSUE/WAIT is ignored.
- Requests are sampled only in IDLE:
  - ch_req or command changes during a transaction have no effect.
  - A requester must deassert ch_req in the cycle after its ch_done, or it may be re-granted.
  - Minimum request-to-request spacing is 3 cycles (IDLE → ISSUE → DONE).
- A mode or sel_in change mid-transaction takes effect at the next IDLE. rr_ptr is not touched in mode 0.
- Latency from ch_req high in IDLE: execute at +1 cycle; ch_done at (cycle of mem_ready)+1.

Decomposition:
- Shared package/header (memory_arbiter.vh):
  - state encodings ARB_IDLE/ISSUE/WAIT/DONE.
  - mode constants ARB_MODE_SEL = 0, ARB_MODE_RR = 1.
  - Legacy MUX_* channel indices reused as sel_in values.
- Sub-module rr_picker: combinational rotate-priority encoder. Inputs req[NUM_CH], ptr; outputs grant index and valid.

Test Plan:
- Mode 0, sel_in = 2, ch_req = 6'b000100, address1 = 0x15, mem_ready 3 cycles after execute:
  - execute pulses once with address1 = 0x15.
  - ch_done = 6'b000100 arrives 1 cycle after mem_ready.
  - rd_data = mem_read_data (e.g. 0xDEAD).
- Mode 1, all six ch_req high from reset, memory replies in 1 cycle:
  - grant order 0,1,2,3,4,5,0.
  - each channel receives exactly one ch_done per pass.
- Mode 0, sel_in = 7 (≥ NUM_CH) or sel_in = 1 with ch_req[1] = 0: no execute, busy stays 0 for 10 cycles.
- mem_ready asserted in the ISSUE cycle: ch_done on the next cycle; total 3 cycles from request to done.
- rst asserted during WAIT: next cycle all outputs 0, no ch_done; later mem_ready is ignored.
- Command inputs changed during WAIT: address1/address2/write_data outputs hold the values latched in IDLE.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
//   Shared definitions for the memory command-port arbiter: FSM state
//   encoding, arbitration mode constants, legacy engine channel indices
//   (still used as sel_in values) and default memory bus widths.
package memory_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W = 10;
    localparam int unsigned MEM_DATA_W = 64;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

    localparam logic ARB_MODE_SEL = 1'b0;
    localparam logic ARB_MODE_RR  = 1'b1;

    // Legacy select-mux channel indices
    localparam logic [3:0] MUX_TRAVERSAL = 4'd0;
    localparam logic [3:0] MUX_EXECUTE   = 4'd1;
    localparam logic [3:0] MUX_CELL      = 4'd2;
    localparam logic [3:0] MUX_INCR      = 4'd3;
    localparam logic [3:0] MUX_EQUAL     = 4'd4;
    localparam logic [3:0] MUX_EDIT      = 4'd5;

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// memory_arbiter_rr_picker
//   Combinational rotate-priority encoder. Returns the first set request
//   found when searching ptr, ptr+1, ... wrapping modulo NUM_CH.
//   req       : per-channel request levels
//   ptr       : index with highest priority
//   grant_idx : winning channel index (0 when valid is low)
//   valid     : at least one request is set
module memory_arbiter_rr_picker #(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              valid
);

    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    logic [IDX_W:0]      sum;

    always_comb begin
        dbl       = {req, req};
        // rot[k] is the request of channel (ptr + k) mod NUM_CH
        rot       = NUM_CH'(dbl >> ptr);
        grant_idx = '0;
        valid     = 1'b0;
        sum       = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                sum   = {1'b0, ptr} + (IDX_W+1)'(k);
                if (sum >= (IDX_W+1)'(NUM_CH)) begin
                    sum = sum - (IDX_W+1)'(NUM_CH);
                end
                grant_idx = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Multiplexes NUM_CH engine channels onto the single memory_unit command
//   port. A winning channel's command is latched in IDLE, issued with a
//   one-cycle execute strobe, and completed with a one-cycle ch_done pulse
//   once memory_unit answers with mem_ready.
//   clk, rst            : clock, synchronous active-high reset
//   mode, sel_in        : 0 = external select by sel_in, 1 = round-robin
//   ch_req, ch_*        : per-channel request level and packed command fields
//   ch_done, ch_grant   : one-hot completion pulse / current owner
//   rd_data             : read data returned to the owner, held afterwards
//   mem_func, execute,
//   address1, address2,
//   write_data          : command port to memory_unit
//   mem_ready,
//   mem_read_data       : memory_unit completion strobe and read result
//   busy                : high in every state except IDLE
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned SEL_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [2*NUM_CH-1:0]      ch_mem_func,
    input  logic [ADDR_W*NUM_CH-1:0] ch_address1,
    input  logic [ADDR_W*NUM_CH-1:0] ch_address2,
    input  logic [DATA_W*NUM_CH-1:0] ch_write_data,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_grant,
    output logic [DATA_W-1:0]        rd_data,
    output logic [1:0]               mem_func,
    output logic                     execute,
    output logic [ADDR_W-1:0]        address1,
    output logic [ADDR_W-1:0]        address2,
    output logic [DATA_W-1:0]        write_data,
    input  logic                     mem_ready,
    input  logic [DATA_W-1:0]        mem_read_data,
    output logic                     busy
);

    localparam int unsigned IDX_W    = $clog2(NUM_CH);
    localparam int unsigned SEL_SPAN = 1 << SEL_W;

    arb_state_e          state_q;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_idx_q;
    logic                txn_mode_q;
    logic [NUM_CH-1:0]   ch_done_q, ch_grant_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [1:0]          mem_func_q;
    logic                execute_q;
    logic [ADDR_W-1:0]   address1_q, address2_q;
    logic [DATA_W-1:0]   write_data_q;
    logic                busy_q;

    logic [SEL_SPAN-1:0] req_ext;
    logic                sel_ok;
    logic [IDX_W-1:0]    rr_idx, win_idx;
    logic                rr_valid, win_valid;
    logic [NUM_CH-1:0]   win_onehot;
    logic [1:0]          win_func;
    logic [ADDR_W-1:0]   win_addr1, win_addr2;
    logic [DATA_W-1:0]   win_wdata;

    memory_arbiter_rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_picker (
        .req       (ch_req),
        .ptr       (rr_ptr_q),
        .grant_idx (rr_idx),
        .valid     (rr_valid)
    );

    // Winner selection and command mux; only consumed in IDLE.
    always_comb begin
        // Zero-extend requests so any sel_in value indexes safely.
        req_ext = SEL_SPAN'(ch_req);
        sel_ok  = (32'(sel_in) < NUM_CH);
        if (mode == ARB_MODE_RR) begin
            win_valid = rr_valid;
            win_idx   = rr_idx;
        end else begin
            win_valid = sel_ok && req_ext[sel_in];
            win_idx   = IDX_W'(sel_in);
        end

        win_onehot = '0;
        win_func   = '0;
        win_addr1  = '0;
        win_addr2  = '0;
        win_wdata  = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (win_idx == IDX_W'(c)) begin
                win_onehot[c] = 1'b1;
                win_func      = ch_mem_func[2*c +: 2];
                win_addr1     = ch_address1[ADDR_W*c +: ADDR_W];
                win_addr2     = ch_address2[ADDR_W*c +: ADDR_W];
                win_wdata     = ch_write_data[DATA_W*c +: DATA_W];
            end
        end

        rr_ptr_d = (32'(grant_idx_q) == NUM_CH - 1) ? '0 : grant_idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= '0;
            grant_idx_q  <= '0;
            txn_mode_q   <= ARB_MODE_SEL;
            ch_done_q    <= '0;
            ch_grant_q   <= '0;
            rd_data_q    <= '0;
            mem_func_q   <= '0;
            execute_q    <= 1'b0;
            address1_q   <= '0;
            address2_q   <= '0;
            write_data_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            ch_done_q <= '0;
            execute_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (win_valid) begin
                        mem_func_q   <= win_func;
                        address1_q   <= win_addr1;
                        address2_q   <= win_addr2;
                        write_data_q <= win_wdata;
                        ch_grant_q   <= win_onehot;
                        grant_idx_q  <= win_idx;
                        // Pointer update follows the mode the grant was made in.
                        txn_mode_q   <= mode;
                        execute_q    <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE, ARB_WAIT: begin
                    if (mem_ready) begin
                        rd_data_q <= mem_read_data;
                        ch_done_q <= ch_grant_q;
                        state_q   <= ARB_DONE;
                    end else begin
                        state_q   <= ARB_WAIT;
                    end
                end
                ARB_DONE: begin
                    if (txn_mode_q == ARB_MODE_RR) begin
                        rr_ptr_q <= rr_ptr_d;
                    end
                    ch_grant_q <= '0;
                    busy_q     <= 1'b0;
                    state_q    <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign ch_done    = ch_done_q;
    assign ch_grant   = ch_grant_q;
    assign rd_data    = rd_data_q;
    assign mem_func   = mem_func_q;
    assign execute    = execute_q;
    assign address1   = address1_q;
    assign address2   = address2_q;
    assign write_data = write_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//   Directed bench for memory_arbiter with a scoreboard of expected
//   completions and a latency-programmable memory responder.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int unsigned NCH = 6;
    localparam int unsigned AW  = MEM_ADDR_W;
    localparam int unsigned DW  = MEM_DATA_W;
    localparam int unsigned SW  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                mode;
    logic [SW-1:0]       sel_in;
    logic [NCH-1:0]      ch_req;
    logic [2*NCH-1:0]    ch_mem_func;
    logic [AW*NCH-1:0]   ch_address1;
    logic [AW*NCH-1:0]   ch_address2;
    logic [DW*NCH-1:0]   ch_write_data;
    logic [NCH-1:0]      ch_done;
    logic [NCH-1:0]      ch_grant;
    logic [DW-1:0]       rd_data;
    logic [1:0]          mem_func;
    logic                execute;
    logic [AW-1:0]       address1;
    logic [AW-1:0]       address2;
    logic [DW-1:0]       write_data;
    logic                mem_ready;
    logic [DW-1:0]       mem_read_data;
    logic                busy;

    typedef struct {
        logic [NCH-1:0] onehot;
        logic [1:0]     func;
        logic [AW-1:0]  a1;
        logic [AW-1:0]  a2;
        logic [DW-1:0]  wd;
        logic [DW-1:0]  rdata;
    } exp_t;

    exp_t        sb[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned mem_lat     = 0;

    always #5 clk = ~clk;

    memory_arbiter #(
        .NUM_CH (NCH),
        .ADDR_W (AW),
        .DATA_W (DW),
        .SEL_W  (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .sel_in        (sel_in),
        .ch_req        (ch_req),
        .ch_mem_func   (ch_mem_func),
        .ch_address1   (ch_address1),
        .ch_address2   (ch_address2),
        .ch_write_data (ch_write_data),
        .ch_done       (ch_done),
        .ch_grant      (ch_grant),
        .rd_data       (rd_data),
        .mem_func      (mem_func),
        .execute       (execute),
        .address1      (address1),
        .address2      (address2),
        .write_data    (write_data),
        .mem_ready     (mem_ready),
        .mem_read_data (mem_read_data),
        .busy          (busy)
    );

    function automatic logic [DW-1:0] resp_of(input logic [AW-1:0] a1, input logic [DW-1:0] wd);
        logic [DW-1:0] k;
        k = DW'(64'hDEAD);
        return k ^ DW'(a1) ^ wd;
    endfunction

    // Memory responder: mem_ready arrives mem_lat cycles after the execute cycle.
    initial begin
        int unsigned cnt;
        bit          armed;
        mem_ready     = 1'b0;
        mem_read_data = '0;
        cnt           = 0;
        armed         = 1'b0;
        forever begin
            @(negedge clk);
            mem_read_data = resp_of(address1, write_data);
            mem_ready     = 1'b0;
            if (execute === 1'b1) begin
                cnt       = mem_lat;
                armed     = (mem_lat != 0);
                mem_ready = (mem_lat == 0);
            end else if (armed) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    armed     = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int unsigned ch, input logic [1:0] f, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [DW-1:0] wd);
        ch_mem_func[2*ch +: 2]     = f;
        ch_address1[AW*ch +: AW]   = a1;
        ch_address2[AW*ch +: AW]   = a2;
        ch_write_data[DW*ch +: DW] = wd;
    endtask

    task automatic push_exp(input int unsigned ch, input logic [1:0] f, input logic [AW-1:0] a1,
                            input logic [AW-1:0] a2, input logic [DW-1:0] wd);
        exp_t e;
        e.onehot     = '0;
        e.onehot[ch] = 1'b1;
        e.func       = f;
        e.a1         = a1;
        e.a2         = a2;
        e.wd         = wd;
        e.rdata      = resp_of(a1, wd);
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"},  ch_done,    '0);
        check({tag, "_grant"}, ch_grant,   '0);
        check({tag, "_rd"},    rd_data,    '0);
        check({tag, "_func"},  mem_func,   '0);
        check({tag, "_exec"},  execute,    '0);
        check({tag, "_a1"},    address1,   '0);
        check({tag, "_a2"},    address2,   '0);
        check({tag, "_wd"},    write_data, '0);
        check({tag, "_busy"},  busy,       '0);
    endtask

    // Runs from the current cycle until ch_done appears (bounded), checking the
    // issued command against the head of the scoreboard every cycle it is owned.
    task automatic wait_done(input int unsigned budget, input int unsigned exp_cyc, input bit scramble);
        exp_t        e;
        int unsigned cyc;
        int unsigned execs;
        bit          issued;
        bit          seen;
        cyc    = 0;
        execs  = 0;
        issued = 1'b0;
        seen   = 1'b0;
        e      = '{onehot: '1, func: '0, a1: '0, a2: '0, wd: '0, rdata: '0};
        if (sb.size() != 0) e = sb.pop_front();
        while (!seen && cyc < budget) begin
            step();
            cyc++;
            if (execute === 1'b1) execs++;
            if (execute === 1'b1 || issued) begin
                issued = 1'b1;
                check("cmd_func",  mem_func,   e.func);
                check("cmd_a1",    address1,   e.a1);
                check("cmd_a2",    address2,   e.a2);
                check("cmd_wd",    write_data, e.wd);
                check("cmd_grant", ch_grant,   e.onehot);
                check("cmd_busy",  busy,       1'b1);
            end
            if (scramble && execute === 1'b1) begin
                for (int unsigned c = 0; c < NCH; c++) begin
                    set_cmd(c, 2'b11, AW'(10'h3F0 + c), AW'(10'h2E0 + c), ~DW'(c));
                end
            end
            if (ch_done !== '0) seen = 1'b1;
        end
        check("done_onehot", ch_done, e.onehot);
        check("done_rdata",  rd_data, e.rdata);
        check("latency",     cyc,     exp_cyc);
        check("exec_count",  execs,   1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        mode          = ARB_MODE_SEL;
        sel_in        = '0;
        ch_req        = '0;
        ch_mem_func   = '0;
        ch_address1   = '0;
        ch_address2   = '0;
        ch_write_data = '0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check("idle_busy", busy, 1'b0);

        // Mode 0, channel 2, memory replies 3 cycles after execute
        mem_lat = 3;
        sel_in  = MUX_CELL;
        set_cmd(2, 2'b01, 10'h015, 10'h0A2, 64'h15);
        push_exp(2, 2'b01, 10'h015, 10'h0A2, 64'h15);
        ch_req = 6'b000100;
        wait_done(20, 5, 1'b0);
        check("t1_rd_dead", rd_data, 64'hDEAD);
        ch_req = '0;
        step();
        check("t1_idle_done",  ch_done,  '0);
        check("t1_idle_grant", ch_grant, '0);
        check("t1_idle_busy",  busy,     1'b0);
        check("t1_rd_held",    rd_data,  64'hDEAD);

        // Mode 0, out-of-range select and unrequested select: no grant
        sel_in = 4'd7;
        ch_req = 6'b111111;
        for (int i = 0; i < 10; i++) begin
            step();
            check("sel7_exec", execute, 1'b0);
            check("sel7_busy", busy,    1'b0);
        end
        sel_in = MUX_EXECUTE;
        ch_req = 6'b111101;
        for (int i = 0; i < 10; i++) begin
            step();
            check("nreq_exec", execute, 1'b0);
            check("nreq_busy", busy,    1'b0);
        end
        ch_req = '0;

        // mem_ready during ISSUE: done two edges after the request is sampled
        mem_lat = 0;
        sel_in  = MUX_INCR;
        set_cmd(3, 2'b10, 10'h1C3, 10'h033, 64'h0123_4567_89AB_CDEF);
        push_exp(3, 2'b10, 10'h1C3, 10'h033, 64'h0123_4567_89AB_CDEF);
        ch_req = 6'b001000;
        wait_done(10, 2, 1'b0);
        ch_req = '0;
        step();

        // Command inputs change during WAIT: latched command must hold
        mem_lat = 4;
        sel_in  = MUX_EDIT;
        set_cmd(5, 2'b11, 10'h2AA, 10'h155, 64'hCAFE_0000_BEEF_0005);
        push_exp(5, 2'b11, 10'h2AA, 10'h155, 64'hCAFE_0000_BEEF_0005);
        ch_req = 6'b100000;
        wait_done(20, 6, 1'b1);
        ch_req = '0;
        step();

        // Round-robin, all channels requesting from pointer 0
        mem_lat = 1;
        mode    = ARB_MODE_RR;
        for (int unsigned i = 0; i < NCH; i++) begin
            set_cmd(i, 2'(i % 4), AW'(10'h100 + i), AW'(10'h200 + i), DW'(64'h1000 * i + 7));
        end
        for (int unsigned i = 0; i <= NCH; i++) begin
            int unsigned c;
            c = i % NCH;
            push_exp(c, 2'(c % 4), AW'(10'h100 + c), AW'(10'h200 + c), DW'(64'h1000 * c + 7));
        end
        ch_req = '1;
        wait_done(20, 3, 1'b0);
        for (int i = 0; i < NCH; i++) wait_done(20, 4, 1'b0);
        ch_req = '0;
        step();

        // Mode 0 grant must leave the round-robin pointer at 1
        mode   = ARB_MODE_SEL;
        sel_in = MUX_EQUAL;
        push_exp(4, 2'd0, 10'h104, 10'h204, 64'h4007);
        ch_req = 6'b010000;
        wait_done(20, 3, 1'b0);
        ch_req = '0;
        step();

        // Pointer 1 with requests on 0 and 2: 2 first, then wrap to 0
        mode = ARB_MODE_RR;
        push_exp(2, 2'd2, 10'h102, 10'h202, 64'h2007);
        push_exp(0, 2'd0, 10'h100, 10'h200, 64'h0007);
        ch_req = 6'b000101;
        wait_done(20, 3, 1'b0);
        ch_req = 6'b000001;
        wait_done(20, 4, 1'b0);
        ch_req = '0;
        step();

        // Reset during WAIT aborts; the late mem_ready is ignored
        mode    = ARB_MODE_SEL;
        mem_lat = 5;
        sel_in  = MUX_EQUAL;
        ch_req  = 6'b010000;
        step();
        check("rst_t_exec", execute, 1'b1);
        step();
        step();
        check("rst_t_wait_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        check_all_zero("rst_wait");
        rst    = 1'b0;
        ch_req = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_rst_done", ch_done, '0);
            check("post_rst_busy", busy,    1'b0);
            check("post_rst_rd",   rd_data, '0);
        end

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
